// File: rtl/ysyx_22040759_imem_if.sv
// rtl/ysyx_22040759_imem_if.sv - fetch request/response and preload bundle for the instruction memory
// Purpose: groups the fetch handshake and the preload write port.
// Ports:   req_valid/req_ready/req_addr  fetch request (PC)
//          rsp_valid/rsp_ready/rsp_inst/rsp_err  fetch response
//          ld_en/ld_idx/ld_data  preload write port
// The master modport belongs to the fetch unit / loader; slave to the memory.
interface ysyx_22040759_imem_if #(
    parameter int DEPTH = 256
);
    localparam int IDX_W = $clog2(DEPTH);

    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_addr;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_inst;
    logic [1:0]       rsp_err;
    logic             ld_en;
    logic [IDX_W-1:0] ld_idx;
    logic [31:0]      ld_data;

    modport master (
        output req_valid, req_addr, rsp_ready, ld_en, ld_idx, ld_data,
        input  req_ready, rsp_valid, rsp_inst, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready, ld_en, ld_idx, ld_data,
        output req_ready, rsp_valid, rsp_inst, rsp_err
    );
endinterface

// File: rtl/ysyx_22040759_imem.sv
// rtl/ysyx_22040759_imem.sv - fixed-latency instruction memory responder
// Purpose: returns the 32-bit word at a fetch PC LATENCY cycles after the
//          request is accepted; one request outstanding at a time.
// Ports:   clk  clock, rising edge
//          rst  asynchronous active-low reset
//          bus  slave side of ysyx_22040759_imem_if (fetch + preload)
module ysyx_22040759_imem #(
    parameter int          LATENCY = 2,
    parameter int          DEPTH   = 256,
    parameter logic [31:0] BASE    = 32'h8000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    ysyx_22040759_imem_if.slave  bus
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic [31:0] addr_q,  addr_d;
    logic [31:0] inst_q,  inst_d;
    logic [1:0]  err_q,   err_d;

    logic [31:0] mem [DEPTH];

    logic             req_ready;
    logic             rsp_valid;
    logic             accept;
    logic             capture;
    logic [31:0]      rd_addr;
    logic [31:0]      rd_off;
    logic [IDX_W-1:0] rd_idx;
    logic             rd_misaligned;
    logic             rd_out_of_range;
    logic [1:0]       rd_err;
    logic [31:0]      rd_inst;

    // Preload port; memory contents deliberately have no reset.
    always_ff @(posedge clk) begin
        if (bus.ld_en) begin
            mem[bus.ld_idx] <= bus.ld_data;
        end
    end

    // Address feeding the lookup: the latched PC while waiting, otherwise the
    // live request (only used when LATENCY == 1 reads on the accept edge).
    // The result lands in registers, so req_addr never reaches an output
    // combinationally.
    always_comb begin
        rd_addr         = (state_q == S_WAIT) ? addr_q : bus.req_addr;
        rd_off          = rd_addr - BASE;
        rd_idx          = rd_off[IDX_W+1:2];
        rd_misaligned   = (rd_addr[1:0] != 2'b00);
        rd_out_of_range = (rd_addr < BASE) || (rd_off[31:IDX_W+2] != '0);
        if (rd_misaligned) begin
            rd_err = 2'b01;
        end else if (rd_out_of_range) begin
            rd_err = 2'b10;
        end else begin
            rd_err = 2'b00;
        end
        rd_inst = (rd_err == 2'b00) ? mem[rd_idx] : 32'h0;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        inst_d    = inst_q;
        err_d     = err_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        accept    = 1'b0;
        capture   = 1'b0;

        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                accept    = bus.req_valid;
            end
            S_WAIT: begin
                // The counter holds the WAIT cycles still to go; the read
                // happens on the edge that takes it to zero.
                if (cnt_q <= 4'd1) begin
                    capture = 1'b1;
                    state_d = S_RESP;
                end
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                req_ready = bus.rsp_ready;
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                    accept  = bus.req_valid;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A new request restarts the sequence from IDLE or from a completing
        // response alike, giving one response every LATENCY cycles.
        if (accept) begin
            addr_d = bus.req_addr;
            if (LATENCY == 1) begin
                capture = 1'b1;
                state_d = S_RESP;
            end else begin
                cnt_d   = 4'(LATENCY - 1);
                state_d = S_WAIT;
            end
        end

        if (capture) begin
            inst_d = rd_inst;
            err_d  = rd_err;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'h0;
            inst_q  <= 32'h0;
            err_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            inst_q  <= inst_d;
            err_q   <= err_d;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_inst  = inst_q;
    assign bus.rsp_err   = err_q;
endmodule
